// File: rtl/branch_pkg.sv
// Shared constants and types for the branch resolution / prediction slice.
package branch_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // 2-bit saturating direction counter; the MSB is the prediction.
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = CTR_WNT;

    // One step toward the resolved direction, saturating at both ends.
    function automatic ctr_t ctr_step(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        unique case (cur)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
            default: nxt = CTR_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// Table of 2-bit saturating counters: one combinational read port (no
// write-to-read bypass) and one synchronous saturating-update port.
module branch_history_table
    import branch_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX     = $clog2(ENTRIES)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [IDX-1:0] rd_idx,
    output logic           rd_taken,
    input  logic           upd_en,
    input  logic [IDX-1:0] upd_idx,
    input  logic           upd_taken
);

    ctr_t table_q [ENTRIES];

    // Counter storage: reset to weak-not-taken, then step on each resolution.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: this array is reset on purpose: prediction must start from a
            // defined weak-not-taken state, so it cannot map onto a plain RAM macro.
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CTR_RESET;
            end
        end else if (upd_en) begin
            // NOTE: non-blocking so the read port sees the old value this cycle.
            table_q[upd_idx] <= ctr_step(table_q[upd_idx], upd_taken);
        end
    end

    assign rd_taken = table_q[rd_idx][1];

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution with registered redirect outputs and an optional
// 2-bit counter direction predictor (enabled by defining BRANCH_PREDICT_EN;
// otherwise prediction is static not-taken).
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] PredPC,
    output logic            PredTaken,
    input  logic            ResValid,
    input  logic [XLEN-1:0] ResPC,
    input  logic [XLEN-1:0] ResImm,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [6:0]      Opcode,
    input  logic [2:0]      Funct3,
    input  logic            ResPredTaken,
    output logic            BranchTaken,
    output logic            Mispredict,
    output logic            RedirectValid,
    output logic [XLEN-1:0] RedirectPC
);

    localparam int IDX = $clog2(BHT_ENTRIES);

    logic            is_branch;
    logic            cond_legal;
    logic            cond_taken;
    logic            actual_taken;
    logic            upd_en;
    logic [XLEN-1:0] redirect_next;
    logic            unused_bits;

    // Evaluate the branch condition and the corrected fetch address.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        is_branch  = (Opcode == OPC_BRANCH);
        cond_legal = 1'b0;
        cond_taken = 1'b0;
        unique case (Funct3)
            F3_BEQ:  begin cond_legal = 1'b1; cond_taken = (SrcA == SrcB); end
            F3_BNE:  begin cond_legal = 1'b1; cond_taken = (SrcA != SrcB); end
            F3_BLT:  begin cond_legal = 1'b1; cond_taken = ($signed(SrcA) <  $signed(SrcB)); end
            F3_BGE:  begin cond_legal = 1'b1; cond_taken = ($signed(SrcA) >= $signed(SrcB)); end
            F3_BLTU: begin cond_legal = 1'b1; cond_taken = (SrcA <  SrcB); end
            F3_BGEU: begin cond_legal = 1'b1; cond_taken = (SrcA >= SrcB); end
            default: begin cond_legal = 1'b0; cond_taken = 1'b0; end
        endcase
        actual_taken  = is_branch & cond_legal & cond_taken;
        upd_en        = ResValid & is_branch & cond_legal;
        redirect_next = actual_taken ? (ResPC + ResImm) : (ResPC + XLEN'(4));
    end

    // Register resolution results; RedirectPC holds when nothing resolves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            BranchTaken   <= 1'b0;
            Mispredict    <= 1'b0;
            RedirectValid <= 1'b0;
            RedirectPC    <= '0;
        end else begin
            BranchTaken   <= ResValid & actual_taken;
            Mispredict    <= ResValid & (actual_taken != ResPredTaken);
            RedirectValid <= ResValid & (actual_taken != ResPredTaken);
            if (ResValid) begin
                RedirectPC <= redirect_next;
            end
        end
    end

`ifdef BRANCH_PREDICT_EN
    branch_history_table #(
        .ENTRIES (BHT_ENTRIES),
        .IDX     (IDX)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (PredPC[IDX+1:2]),
        .rd_taken  (PredTaken),
        .upd_en    (upd_en),
        .upd_idx   (ResPC[IDX+1:2]),
        .upd_taken (actual_taken)
    );
    // Only the index bits of the fetch PC reach the table.
    assign unused_bits = ^PredPC;
`else
    // Static not-taken: every taken branch becomes a mispredict.
    assign PredTaken   = 1'b0;
    assign unused_bits = ^{PredPC, upd_en};
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed cases plus random
// traffic against a behavioural model, with a queue-based scoreboard.
module tb_branch_predict_unit;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [XLEN-1:0] PredPC;
    logic            PredTaken;
    logic            ResValid;
    logic [XLEN-1:0] ResPC, ResImm, SrcA, SrcB;
    logic [6:0]      Opcode;
    logic [2:0]      Funct3;
    logic            ResPredTaken;
    logic            BranchTaken, Mispredict, RedirectValid;
    logic [XLEN-1:0] RedirectPC;

    branch_predict_unit #(.XLEN(XLEN), .BHT_ENTRIES(ENTRIES)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PredPC        (PredPC),
        .PredTaken     (PredTaken),
        .ResValid      (ResValid),
        .ResPC         (ResPC),
        .ResImm        (ResImm),
        .SrcA          (SrcA),
        .SrcB          (SrcB),
        .Opcode        (Opcode),
        .Funct3        (Funct3),
        .ResPredTaken  (ResPredTaken),
        .BranchTaken   (BranchTaken),
        .Mispredict    (Mispredict),
        .RedirectValid (RedirectValid),
        .RedirectPC    (RedirectPC)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              taken;
        bit              mis;
        logic [XLEN-1:0] rpc;
    } exp_t;

    exp_t            sb[$];
    int              total = 0;
    int              bad   = 0;

    // Reference model state: plain integer counters 0..3 and the held target.
    int              m_ctr [ENTRIES];
    logic [XLEN-1:0] m_rpc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [XLEN-1:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit model_pred(input logic [XLEN-1:0] pc);
`ifdef BRANCH_PREDICT_EN
        return m_ctr[idx_of(pc)] >= 2;
`else
        return 1'b0;
`endif
    endfunction

    // Branch outcome from the ISA rules; legal reports whether Funct3 names a condition.
    function automatic bit model_taken(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                       output bit legal);
        int sa, sb_;
        sa = int'(a);
        sb_ = int'(b);
        legal = (opc == 7'h63) && (f3 != 3'd2) && (f3 != 3'd3);
        if (!legal) return 1'b0;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb_;
            3'd5: return sa >= sb_;
            3'd6: return a < b;
            default: return a >= b;
        endcase
    endfunction

    // One cycle of stimulus: check the prediction before the edge, then queue
    // the registered result expected after it.
    task automatic drive(input bit rst, input bit v, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] imm, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [6:0] opc,
                         input logic [2:0] f3, input bit pt, input logic [XLEN-1:0] ppc);
        exp_t e;
        bit   legal, tk;
        rst_n = rst; ResValid = v; ResPC = pc; ResImm = imm; SrcA = a; SrcB = b;
        Opcode = opc; Funct3 = f3; ResPredTaken = pt; PredPC = ppc;
        #1;
        check("pred_taken", {63'd0, PredTaken}, {63'd0, model_pred(ppc)});
        tk = model_taken(opc, f3, a, b, legal);
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
            m_rpc = '0;
            e = '{taken: 1'b0, mis: 1'b0, rpc: '0};
        end else if (!v) begin
            e = '{taken: 1'b0, mis: 1'b0, rpc: m_rpc};
        end else begin
            m_rpc = tk ? pc + imm : pc + 32'd4;
            e = '{taken: tk, mis: (tk != pt), rpc: m_rpc};
            if (legal) begin
                if (tk && m_ctr[idx_of(pc)] < 3) m_ctr[idx_of(pc)]++;
                if (!tk && m_ctr[idx_of(pc)] > 0) m_ctr[idx_of(pc)]--;
            end
        end
        @(posedge clk);
        sb.push_back(e);
        #1;
    endtask

    task automatic idle(input logic [XLEN-1:0] ppc);
        drive(1'b1, 1'b0, '0, '0, '0, '0, 7'h63, 3'd0, 1'b0, ppc);
    endtask

    // Monitor: outputs are registered every cycle, so compare once per cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("branch_taken",   {63'd0, BranchTaken},   {63'd0, e.taken});
            check("mispredict",     {63'd0, Mispredict},    {63'd0, e.mis});
            check("redirect_valid", {63'd0, RedirectValid}, {63'd0, e.mis});
            check("redirect_pc",    {32'd0, RedirectPC},    {32'd0, e.rpc});
        end
    end

    initial begin
        logic [XLEN-1:0] a, b, pc, ppc, imm;
        logic [6:0]      opc;
        // Power-on: reset with a resolve present that must be discarded.
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
        m_rpc = '0;
        rst_n = 1'b0; ResValid = 1'b1; ResPC = 32'h100; ResImm = 32'h20;
        SrcA = 32'd5; SrcB = 32'd5; Opcode = 7'h63; Funct3 = 3'd0;
        ResPredTaken = 1'b0; PredPC = '0;
        @(posedge clk);
        #1;

        // Sweep every index: weak-not-taken predicts not-taken; outputs idle.
        for (int i = 0; i < ENTRIES; i++) idle(32'(i) << 2);

        // BEQ taken at 0x100, predicted not-taken.
        drive(1'b1, 1'b1, 32'h100, 32'h20, 32'd5, 32'd5, 7'h63, 3'd0, 1'b0, 32'h100);
        idle(32'h100);

        // Signed vs unsigned compare of -1 against 1.
        drive(1'b1, 1'b1, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 7'h63, 3'd4, 1'b0, 32'h300);
        drive(1'b1, 1'b1, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 7'h63, 3'd6, 1'b1, 32'h300);

        // Saturate up, then walk down two steps at index of 0x200.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b1, 32'h200, 32'h8, 32'd7, 32'd7, 7'h63, 3'd0, 1'b0, 32'h200);
        for (int i = 0; i < 2; i++)
            drive(1'b1, 1'b1, 32'h200, 32'h8, 32'd7, 32'd8, 7'h63, 3'd0, 1'b1, 32'h200);
        idle(32'h200);

        // Same-index lookup and update: old value now, new value next cycle.
        drive(1'b1, 1'b1, 32'h400, 32'h10, 32'd1, 32'd2, 7'h63, 3'd1, 1'b0, 32'h400);
        idle(32'h400);

        // Non-branch with a taken prediction; then illegal Funct3 branch.
        drive(1'b1, 1'b1, 32'h500, 32'h10, 32'd3, 32'd3, 7'h33, 3'd0, 1'b1, 32'h500);
        drive(1'b1, 1'b1, 32'h500, 32'h10, 32'd3, 32'd3, 7'h63, 3'd2, 1'b1, 32'h500);
        idle(32'h500);

        // Wrap-around of the taken target.
        drive(1'b1, 1'b1, 32'hFFFF_FFF0, 32'h20, 32'd0, 32'd0, 7'h63, 3'd0, 1'b0, 32'h0);
        idle(32'h0);

        // Random traffic over a small PC window so indices collide often.
        for (int n = 0; n < 600; n++) begin
            pc  = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
            ppc = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom : ~a);
            imm = $urandom & 32'hFFFF_FFFE;
            opc = ($urandom_range(0, 9) < 8) ? 7'h63 : 7'($urandom);
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), pc, imm, a, b,
                  opc, 3'($urandom), 1'($urandom), ppc);
        end
        idle(32'h0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            bad++;
            total++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Resolves conditional branches in the execute stage and keeps a table of 2-bit saturating counters that predicts branch direction at fetch. It generalises the combinational branch comparator: datapath width and table depth are parameters, and the outputs are registered. Each resolution reports the actual outcome, whether the prediction was wrong, and the corrected fetch address. It sits between fetch (prediction lookup) and execute (resolution), and drives the pipeline redirect/flush logic.

## Interface
- `XLEN`, 32: datapath and PC width.
- `BHT_ENTRIES`, 64: counter count, power of two ≥ 4. `IDX = $clog2(BHT_ENTRIES)`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `PredPC` in XLEN: fetch PC for lookup.
- `PredTaken` out 1: combinational prediction for `PredPC`.
- `ResValid` in 1: resolve request this cycle.
- `ResPC` in XLEN: PC of the resolving instruction.
- `ResImm` in XLEN: sign-extended B-immediate.
- `SrcA`, `SrcB` in XLEN: rs1/rs2 operands.
- `Opcode` in 7: instruction opcode.
- `Funct3` in 3: branch condition.
- `ResPredTaken` in 1: prediction carried down the pipe with the instruction.
- `BranchTaken` out 1: registered actual outcome.
- `Mispredict` out 1: registered; actual outcome ≠ `ResPredTaken`.
- `RedirectValid` out 1: registered; equals `Mispredict`.
- `RedirectPC` out XLEN: registered corrected fetch address.

## Operation
- Counter index: `PC[IDX+1:2]`. Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. `PredTaken = counter[1]`.
- A branch is `Opcode == 7'b1100011`.
- Branch conditions by `Funct3`:
  - 000 BEQ, 001 BNE: equality.
  - 100 BLT, 101 BGE: signed compare.
  - 110 BLTU, 111 BGEU: unsigned compare.
  - 010 and 011: not-taken, no counter update.
- On `ResValid` with a branch and a legal `Funct3`:
  - The counter at index(`ResPC`) moves one step toward the actual outcome.
  - It saturates at 00 and 11.
- `ResValid` with a non-branch:
  - `BranchTaken = 0`; no counter update.
  - If `ResPredTaken = 1`, this is a mispredict.
- Redirect target:
  - Actual taken: `RedirectPC = ResPC + ResImm`.
  - Actual not taken: `RedirectPC = ResPC + 4`.
  - Both sums wrap modulo 2^XLEN.
- `ResValid = 0`: `BranchTaken`, `Mispredict` and `RedirectValid` are 0 the next cycle. `RedirectPC` holds its value.

## Timing
- Prediction: combinational, 0-cycle, from the current table state.
- Resolution: 1-cycle latency. Outputs are valid on the edge after `ResValid`. The unit accepts one resolution per cycle with no stall.
- Counter updates take effect on the same edge the outputs register.
- Lookup and update to the same index in the same cycle: `PredTaken` returns the old value (no bypass). The new value is visible on the next cycle.
- Reset (`rst_n = 0` at an edge):
  - All counters go to 01.
  - `BranchTaken`, `Mispredict` and `RedirectValid` go to 0; `RedirectPC` goes to 0.
  - A `ResValid` present in that cycle is discarded.
  - Reset mid-stream drops in-flight results; no redirect is issued for them.

## Configuration
- `BRANCH_PREDICT_EN` defined: counter table present, behaviour as above.
- `BRANCH_PREDICT_EN` undefined:
  - No table is instantiated and `PredTaken` is tied to 0 (static not-taken).
  - Resolution and redirect logic are unchanged; a mispredict occurs exactly when a branch is taken.

## Structure
- Shared package `branch_pkg` holds:
  - `OPC_BRANCH`
  - Funct3 constants (`F3_BEQ` … `F3_BGEU`)
  - 2-bit counter enum and `CTR_RESET = 2'b01`
- Sub-module `branch_history_table`: counter array with one combinational read port, one synchronous saturating-update port, and synchronous active-low reset. It is instantiated only under `BRANCH_PREDICT_EN`.

## Test plan
1. Reset for 1 cycle, then sweep `PredPC` across all indices -> `PredTaken = 0` everywhere; all registered outputs 0.
2. BEQ at PC 0x100, Src 5/5, Imm 0x20, `ResPredTaken = 0` -> next cycle `BranchTaken = 1`, `Mispredict = 1`, `RedirectPC = 0x120`; `PredTaken(0x100)` becomes 1.
3. `SrcA = 0xFFFFFFFF`, `SrcB = 1`:
   - BLT -> taken.
   - BLTU -> not taken, with `ResPredTaken = 1` -> `RedirectPC = ResPC + 4`.
4. Three taken updates at one index (counter 11), then one not-taken -> counter 10, `PredTaken` still 1; a second not-taken -> 01, `PredTaken = 0`.
5. Same-index lookup and update in one cycle -> old `PredTaken` that cycle, new value next cycle. Non-branch opcode with `ResPredTaken = 1` -> `Mispredict = 1`, `RedirectPC = PC + 4`, table unchanged.
6. Build without `BRANCH_PREDICT_EN`; BNE taken -> `PredTaken = 0` always, `Mispredict = 1`, `RedirectPC = PC + Imm`.
